// File: rtl/tile_painter_if.sv
// Request and frame-buffer write bundle shared by the game FSM, tile_painter
// and the frame-buffer write port.
interface tile_painter_if #(
    parameter int ADDR_W = 19,
    parameter int IDX_W  = 8
);
    // Handshake: a request transfers on the rising edge where req_valid && req_ready.
    // req_valid may stay high; nothing is queued and fields are sampled only on that edge.
    logic              req_valid;
    logic              req_ready;
    logic              req_clear;
    logic [5:0]        req_col;
    logic [4:0]        req_row;
    logic [IDX_W-1:0]  req_index;
    logic [IDX_W-1:0]  req_border;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [IDX_W-1:0]  wr_data;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    modport master (
        output req_valid, req_clear, req_col, req_row, req_index, req_border,
        input  req_ready, wr_en, wr_addr, wr_data, done, err, dbg_state
    );

    modport slave (
        input  req_valid, req_clear, req_col, req_row, req_index, req_border,
        output req_ready, wr_en, wr_addr, wr_data, done, err, dbg_state
    );
endinterface

// File: rtl/tile_painter.sv
// Paints one bordered TILE x TILE cell, or clears the whole frame, into the
// palette-index frame buffer through its write port, one pixel per clock.
module tile_painter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int TILE   = 16,
    parameter int ADDR_W = 19,
    parameter int IDX_W  = 8
) (
    input  logic          iVGA_CLK,
    input  logic          reset,
    tile_painter_if.slave bus
);
    localparam int                TW         = $clog2(TILE);
    localparam logic [5:0]        COLS       = 6'(H_RES / TILE);
    localparam logic [4:0]        ROWS       = 5'(V_RES / TILE);
    localparam logic [TW-1:0]     T_LAST     = TW'(TILE - 1);
    localparam logic [TW-1:0]     T_ONE      = TW'(1);
    localparam logic [ADDR_W-1:0] A_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_RES - TILE + 1);
    localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(TILE * H_RES);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(TILE);

    typedef enum logic [2:0] {IDLE, PAINT, CLEAR, DONE, ERR} state_t;

    state_t            state_q, state_n;
    logic [TW-1:0]     px_q, px_n, py_q, py_n;
    logic [IDX_W-1:0]  fill_q, fill_n, border_q, border_n;
    logic              wr_en_n, done_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [IDX_W-1:0]  data_n;
    logic [ADDR_W-1:0] base;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.dbg_state = state_q;

    // Both strides are constants, so these multiplies reduce to shifts and adds.
    assign base = ADDR_W'(bus.req_row) * ROW_STRIDE + ADDR_W'(bus.req_col) * COL_STRIDE;

    function automatic logic on_edge(input logic [TW-1:0] x, input logic [TW-1:0] y);
        return (x == '0) || (x == T_LAST) || (y == '0) || (y == T_LAST);
    endfunction

    always_comb begin
        state_n  = state_q;
        px_n     = px_q;
        py_n     = py_q;
        fill_n   = fill_q;
        border_n = border_q;
        addr_n   = bus.wr_addr;
        data_n   = bus.wr_data;
        wr_en_n  = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_clear) begin
                        state_n = CLEAR;
                        fill_n  = bus.req_index;
                        addr_n  = '0;
                        data_n  = bus.req_index;
                        wr_en_n = 1'b1;
                    end else if ((bus.req_col >= COLS) || (bus.req_row >= ROWS)) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end else begin
                        // First pixel goes out on the cycle right after accept.
                        state_n  = PAINT;
                        fill_n   = bus.req_index;
                        border_n = bus.req_border;
                        px_n     = '0;
                        py_n     = '0;
                        addr_n   = base;
                        data_n   = bus.req_border;
                        wr_en_n  = 1'b1;
                    end
                end
            end
            PAINT: begin
                if (px_q != T_LAST) begin
                    px_n    = px_q + T_ONE;
                    addr_n  = bus.wr_addr + A_ONE;
                    wr_en_n = 1'b1;
                    data_n  = on_edge(px_n, py_q) ? border_q : fill_q;
                end else if (py_q != T_LAST) begin
                    px_n    = '0;
                    py_n    = py_q + T_ONE;
                    addr_n  = bus.wr_addr + LINE_STEP;
                    wr_en_n = 1'b1;
                    data_n  = border_q;
                end else begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end
            CLEAR: begin
                if (bus.wr_addr == FRAME_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    addr_n  = bus.wr_addr + A_ONE;
                    data_n  = fill_q;
                    wr_en_n = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            px_q        <= '0;
            py_q        <= '0;
            fill_q      <= '0;
            border_q    <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state_q     <= state_n;
            px_q        <= px_n;
            py_q        <= py_n;
            fill_q      <= fill_n;
            border_q    <= border_n;
            bus.wr_en   <= wr_en_n;
            bus.wr_addr <= addr_n;
            bus.wr_data <= data_n;
            bus.done    <= done_n;
            bus.err     <= err_n;
        end
    end
endmodule

// File: doc/tile_painter.md
Name: tile_painter

Overview:
- Write-side counterpart of the VGA scan-out path. The VGA path reads 8-bit palette indices from the 640x480 index frame buffer, one per ADDR.
- This block writes indices into that same buffer through its second write port.
- Game logic issues one request per Tetris cell. The block paints a TILE x TILE square (fill colour plus a 1-pixel border colour), or clears the whole frame to one index.
- Sits between the game FSM and the frame-buffer RAM write port.

Parameters:
- H_RES, 640: active pixels per line; frame-buffer row stride.
- V_RES, 480: active lines.
- TILE, 16: tile edge in pixels; power of two, at least 2.
- ADDR_W, 19: frame-buffer address width; must hold H_RES*V_RES-1.
- IDX_W, 8: palette index width.

Ports:
- iVGA_CLK  in  1  single clock, shared with the frame-buffer write port.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on the edge where req_valid && req_ready.
- req_clear  in  1  1 = full-frame clear; col, row and border inputs are ignored.
- req_col  in  6  tile column, 0..H_RES/TILE-1.
- req_row  in  5  tile row, 0..V_RES/TILE-1.
- req_index  in  IDX_W  fill index (clear index when req_clear=1).
- req_border  in  IDX_W  border index.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  pixel address = y*H_RES + x.
- wr_data  out  IDX_W  index written.
- done  out  1  one-cycle pulse when an operation completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state=IDLE; req_ready=1.
  - wr_en=0, wr_addr=0, wr_data=0, done=0, err=0.
  - Reset during PAINT or CLEAR aborts the operation: no further writes, no done pulse.
- All outputs except req_ready are registered. req_ready is decoded from state==IDLE.
- On accept, all request fields are latched. Input changes after accept have no effect.
- req_valid while not ready is ignored. Requests are not queued.
- FSM states: IDLE, PAINT, CLEAR, DONE, ERR.
- IDLE transitions on accept:
  - req_clear=1 -> CLEAR.
  - Otherwise, req_col >= H_RES/TILE or req_row >= V_RES/TILE -> ERR.
  - Otherwise -> PAINT. base = req_row*TILE*H_RES + req_col*TILE is computed at accept (constant multiplies only).
- PAINT:
  - Counters px (inner) and py (outer), each 0..TILE-1.
  - One write per cycle, no gaps.
  - wr_addr starts at base, increments by 1 along a line, and advances by H_RES-TILE+1 at each line end. The address is kept incrementally; no runtime multiplier.
  - wr_data = req_border if px==0, px==TILE-1, py==0 or py==TILE-1; otherwise req_index.
- PAINT timing: with accept on edge k, wr_en is high for cycles k+1..k+TILE*TILE (256 at default). Leave PAINT after px=py=TILE-1.
- CLEAR: wr_addr runs 0..H_RES*V_RES-1 contiguously with wr_data=req_index. Write count is 307200 at default.
- DONE: exactly one cycle. done=1, wr_en=0, req_ready=0. Next state IDLE, so req_ready returns one cycle after done.
- ERR: exactly one cycle. err=1, no writes, req_ready=0. Next state IDLE.
- wr_en=0 in IDLE, DONE and ERR. wr_addr and wr_data hold their last value while wr_en=0.
- Boundary rules:
  - The last tile (col 39, row 29) ends exactly at address H_RES*V_RES-1.
  - No write may ever reach an address >= H_RES*V_RES.
  - A range violation reports err only; the block never clips.
- done and err are never high in the same cycle.

Test Plan:
- Reset, then release -> req_ready=1; wr_en, done, err all 0; no writes while idle with req_valid=0.
- Paint col=0, row=0, fill=0x05, border=0x0F:
  - 256 consecutive writes.
  - First write addr 0 data 0x0F; addr 641 data 0x05; addr 655 data 0x0F; last addr 9615 data 0x0F.
  - done one cycle after the last write; req_ready one cycle later.
- Paint col=39, row=29 -> first addr 297584, last addr 307199; no address >= 307200.
- Out of range:
  - col=40, row=0 -> err pulse at k+1, zero writes, req_ready back at k+2.
  - Same for row=30.
- Hold req_valid high with new data throughout a PAINT -> the second request is accepted only once, in the first IDLE cycle after DONE; the first tile's data is unaffected.
- Stress cases:
  - Clear with index 0x00 -> 307200 writes at addresses 0..307199 in order, then done.
  - Assert reset after the 100th write of a paint -> wr_en drops without waiting for a clock edge, no done pulse, req_ready=1 after release.
